// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: state, opcode and datapath-select encodings shared by the RV32I multicycle controller.
package rv_ctrl_pkg;
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_LD_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_EXEC_I   = 4'd7;
  localparam logic [3:0] S_ALU_WB   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_TRAP     = 4'd12;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] A_PC = 2'd0, A_RS1 = 2'd1, A_OLDPC = 2'd2;
  localparam logic [1:0] B_RS2 = 2'd0, B_FOUR = 2'd1, B_IMM = 2'd2;
  localparam logic [1:0] ALU_ADD = 2'd0, ALU_BR = 2'd1, ALU_FN = 2'd2;
  localparam logic [1:0] PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_ALU_LSB0 = 2'd2;
  localparam logic [1:0] WB_ALUOUT = 2'd0, WB_MDR = 2'd1, WB_PC = 2'd2;
  localparam logic [1:0] TRAP_NONE = 2'd0, TRAP_ILLEGAL = 2'd1, TRAP_TIMEOUT = 2'd2;

  function automatic logic is_mem_state(input logic [3:0] s);
    return s == S_FETCH || s == S_MEM_RD || s == S_MEM_WR;
  endfunction
endpackage

// File: rtl/rv_multicycle_ctrl_mem_wait_timer.sv
// mem_wait_timer: counts stalled memory cycles within one state and flags a bus timeout.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_mem_ready,
  input  logic i_state_change,
  output logic o_timeout
);
  localparam int W = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LIM = W'(MEM_TIMEOUT);
  logic [W-1:0] r_cnt;
  logic w_wait;
  assign w_wait = i_active & ~i_mem_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_state_change) r_cnt <= '0;
    else if (w_wait) r_cnt <= r_cnt + 1'b1;
  assign o_timeout = (MEM_TIMEOUT != 0) && w_wait && r_cnt == LIM;
endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: multicycle RV32I control FSM driving a shared ALU/memory/regfile datapath.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       mem_to_reg,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);
  logic [3:0]       r_state, w_next;
  logic [1:0]       r_trap_cause;
  logic [CNT_W-1:0] r_instret;
  logic             w_timeout;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk           (clk),
    .rst           (rst),
    .i_active      (is_mem_state(r_state)),
    .i_mem_ready   (mem_ready),
    .i_state_change(w_next != r_state),
    .o_timeout     (w_timeout)
  );

  always_comb begin
    w_next = S_TRAP;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : w_timeout ? S_TRAP : S_FETCH;
      S_DECODE:
        case (opcode)
          OP_LOAD, OP_STORE: w_next = S_MEM_ADDR;
          OP_R:              w_next = S_EXEC_R;
          OP_I:              w_next = S_EXEC_I;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
          default:           w_next = S_TRAP;
        endcase
      S_MEM_ADDR: w_next = opcode == OP_LOAD ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next = mem_ready ? S_LD_WB : w_timeout ? S_TRAP : S_MEM_RD;
      S_MEM_WR:   w_next = mem_ready ? S_FETCH : w_timeout ? S_TRAP : S_MEM_WR;
      S_EXEC_R, S_EXEC_I: w_next = S_ALU_WB;
      S_LD_WB, S_ALU_WB, S_BRANCH, S_JAL, S_JALR: w_next = S_FETCH;
      default:    w_next = S_TRAP;
    endcase
  end

  // Only DECODE traps on an opcode; every other entry into TRAP is a stalled memory state.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state      <= S_FETCH;
      r_trap_cause <= TRAP_NONE;
      r_instret    <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP && r_state != S_TRAP)
        r_trap_cause <= r_state == S_DECODE ? TRAP_ILLEGAL : TRAP_TIMEOUT;
      if (w_next == S_FETCH && r_state != S_FETCH)
        r_instret <= r_instret + 1'b1;
    end

  always_comb begin
    mem_req = 1'b0; mem_we = 1'b0; iord = 1'b0; ir_write = 1'b0;
    pc_write = 1'b0; pc_write_cond = 1'b0; pc_src = PC_ALU;
    alu_src_a = A_PC; alu_src_b = B_RS2; alu_op = ALU_ADD;
    reg_write = 1'b0; mem_to_reg = WB_ALUOUT; halted = 1'b0;
    trap_cause = r_trap_cause; instret = r_instret;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1; alu_src_b = B_FOUR;
        ir_write = mem_ready; pc_write = mem_ready;
      end
      S_DECODE:   begin alu_src_a = A_OLDPC; alu_src_b = B_IMM; end
      S_MEM_ADDR: begin alu_src_a = A_RS1; alu_src_b = B_IMM; end
      S_MEM_RD:   begin mem_req = 1'b1; iord = 1'b1; end
      S_LD_WB:    begin reg_write = 1'b1; mem_to_reg = WB_MDR; end
      S_MEM_WR:   begin mem_req = 1'b1; mem_we = 1'b1; iord = 1'b1; end
      S_EXEC_R:   begin alu_src_a = A_RS1; alu_op = ALU_FN; end
      S_EXEC_I:   begin alu_src_a = A_RS1; alu_src_b = B_IMM; alu_op = ALU_FN; end
      S_ALU_WB:   reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = A_RS1; alu_op = ALU_BR; pc_write_cond = 1'b1; pc_src = PC_ALUOUT;
      end
      S_JAL: begin
        pc_write = 1'b1; pc_src = PC_ALUOUT; reg_write = 1'b1; mem_to_reg = WB_PC;
      end
      S_JALR: begin
        alu_src_a = A_RS1; alu_src_b = B_IMM; pc_write = 1'b1; pc_src = PC_ALU_LSB0;
        reg_write = 1'b1; mem_to_reg = WB_PC;
      end
      S_TRAP:     halted = 1'b1;
      default:    halted = 1'b1;
    endcase
    // Asynchronous reset must also silence the combinational FETCH request.
    if (rst) begin
      mem_req = 1'b0; mem_we = 1'b0; iord = 1'b0; ir_write = 1'b0;
      pc_write = 1'b0; pc_write_cond = 1'b0; pc_src = '0;
      alu_src_a = '0; alu_src_b = '0; alu_op = '0;
      reg_write = 1'b0; mem_to_reg = '0; halted = 1'b0;
      trap_cause = '0; instret = '0;
    end
  end
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb_rv_multicycle_ctrl: instruction-level reference model with randomized opcodes and memory stalls.
module tb_rv_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, reg_write, halted;
  logic [1:0]  pc_src, alu_src_a, alu_src_b, alu_op, mem_to_reg, trap_cause;
  logic [31:0] instret;
  logic [19:0] w_obs;
  logic [31:0] exp_instret;
  int          n_checks = 0;
  int          n_fail = 0;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYPE = 7'b0110011,
                         ITYPE = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;

  rv_multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .halted(halted),
    .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  assign w_obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
                  alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, halted, trap_cause};

  function automatic logic [19:0] mk(input logic req, we, io, irw, pcw, pcc,
                                     input logic [1:0] ps, a, b, op,
                                     input logic rw, input logic [1:0] m2r,
                                     input logic hlt, input logic [1:0] tc);
    return {req, we, io, irw, pcw, pcc, ps, a, b, op, rw, m2r, hlt, tc};
  endfunction

  logic [19:0] e_fw, e_fg, e_dec, e_madr, e_mrd, e_ldwb, e_mwr, e_exr, e_exi, e_alwb,
               e_br, e_jal, e_jalr, e_trap1, e_trap2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive mem_ready for one cycle, check the control vector mid-cycle, advance past the edge.
  task automatic step(input logic mr, input logic [19:0] exp, input string tag);
    mem_ready = mr;
    @(negedge clk);
    check(tag, w_obs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    #2;
    check("rst_outs", w_obs, 0);
    check("rst_instret", instret, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_instret = 0;
  endtask

  function automatic logic legal(input logic [6:0] op);
    return op inside {LOAD, STORE, RTYPE, ITYPE, BR, JAL, JALR};
  endfunction

  // One whole instruction: fw fetch stalls, mw memory stalls; illegal opcodes end in a reset.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
    opcode = op;
    check("instret", instret, exp_instret);
    repeat (fw) step(1'b0, e_fw, "fetch_wait");
    step(1'b1, e_fg, "fetch");
    step(1'($urandom), e_dec, "decode");
    case (op)
      LOAD: begin
        step(1'($urandom), e_madr, "ld_addr");
        repeat (mw) step(1'b0, e_mrd, "mem_rd_wait");
        step(1'b1, e_mrd, "mem_rd");
        step(1'($urandom), e_ldwb, "ld_wb");
      end
      STORE: begin
        step(1'($urandom), e_madr, "st_addr");
        repeat (mw) step(1'b0, e_mwr, "mem_wr_wait");
        step(1'b1, e_mwr, "mem_wr");
      end
      RTYPE: begin step(1'($urandom), e_exr, "exec_r"); step(1'($urandom), e_alwb, "alu_wb_r"); end
      ITYPE: begin step(1'($urandom), e_exi, "exec_i"); step(1'($urandom), e_alwb, "alu_wb_i"); end
      BR:    step(1'($urandom), e_br, "branch");
      JAL:   step(1'($urandom), e_jal, "jal");
      JALR:  step(1'($urandom), e_jalr, "jalr");
      default: begin
        repeat (20) step(1'($urandom), e_trap1, "trap_illegal");
        check("trap_instret", instret, exp_instret);
        do_reset();
        return;
      end
    endcase
    exp_instret++;
  endtask

  initial begin
    e_fw    = mk(1,0,0,0,0,0, 2'd0,2'd0,2'd1,2'd0, 0,2'd0, 0,2'd0);
    e_fg    = mk(1,0,0,1,1,0, 2'd0,2'd0,2'd1,2'd0, 0,2'd0, 0,2'd0);
    e_dec   = mk(0,0,0,0,0,0, 2'd0,2'd2,2'd2,2'd0, 0,2'd0, 0,2'd0);
    e_madr  = mk(0,0,0,0,0,0, 2'd0,2'd1,2'd2,2'd0, 0,2'd0, 0,2'd0);
    e_mrd   = mk(1,0,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,2'd0, 0,2'd0);
    e_ldwb  = mk(0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 1,2'd1, 0,2'd0);
    e_mwr   = mk(1,1,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,2'd0, 0,2'd0);
    e_exr   = mk(0,0,0,0,0,0, 2'd0,2'd1,2'd0,2'd2, 0,2'd0, 0,2'd0);
    e_exi   = mk(0,0,0,0,0,0, 2'd0,2'd1,2'd2,2'd2, 0,2'd0, 0,2'd0);
    e_alwb  = mk(0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 1,2'd0, 0,2'd0);
    e_br    = mk(0,0,0,0,0,1, 2'd1,2'd1,2'd0,2'd1, 0,2'd0, 0,2'd0);
    e_jal   = mk(0,0,0,0,1,0, 2'd1,2'd0,2'd0,2'd0, 1,2'd2, 0,2'd0);
    e_jalr  = mk(0,0,0,0,1,0, 2'd2,2'd1,2'd2,2'd0, 1,2'd2, 0,2'd0);
    e_trap1 = mk(0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,2'd0, 1,2'd1);
    e_trap2 = mk(0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,2'd0, 1,2'd2);
    opcode = ITYPE;
    exp_instret = 0;
    do_reset();

    run_instr(ITYPE, 0, 0);
    run_instr(LOAD, 0, 3);
    run_instr(JALR, 0, 0);
    run_instr(STORE, 1, 2);
    run_instr(BR, 0, 0);
    run_instr(JAL, 2, 0);
    run_instr(RTYPE, 0, 0);
    check("instret_7", instret, exp_instret);
    run_instr(7'b1111111, 0, 0);

    // Fetch stall: sixteen idle cycles expire the timer, fifteen plus a late ready do not.
    opcode = ITYPE;
    repeat (16) step(1'b0, e_fw, "to_fetch_wait");
    step(1'b0, e_trap2, "trap_timeout");
    do_reset();
    run_instr(ITYPE, 15, 0);
    run_instr(LOAD, 0, 15);
    opcode = LOAD;
    step(1'b1, e_fg, "to_ld_fetch");
    step(1'b0, e_dec, "to_ld_dec");
    step(1'b0, e_madr, "to_ld_addr");
    repeat (16) step(1'b0, e_mrd, "to_mem_rd_wait");
    repeat (3) step(1'($urandom), e_trap2, "trap_rd_timeout");
    check("to_instret", instret, exp_instret);
    do_reset();

    for (int i = 0; i < 60; i++) begin
      logic [6:0] op;
      int pick = $urandom_range(0, 15);
      op = pick == 0 ? 7'($urandom) : (pick < 3 ? LOAD : pick < 5 ? STORE : pick < 7 ? RTYPE :
           pick < 9 ? ITYPE : pick < 11 ? BR : pick < 13 ? JAL : JALR);
      if (pick != 0 && !legal(op)) op = ITYPE;
      run_instr(op, ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 3),
                ($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 4));
    end

    // Asynchronous reset in the middle of a stalled store.
    run_instr(RTYPE, 0, 0);
    opcode = STORE;
    step(1'b1, e_fg, "ar_fetch");
    step(1'b0, e_dec, "ar_dec");
    step(1'b0, e_madr, "ar_addr");
    step(1'b0, e_mwr, "ar_mem_wr");
    mem_ready = 1'b0;
    #2;
    check("ar_req_before", mem_req, 1);
    rst = 1'b1;
    #1;
    check("ar_req_async", mem_req, 0);
    check("ar_we_async", mem_we, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_instret = 0;
    check("ar_trap_cause", trap_cause, 0);
    run_instr(ITYPE, 0, 0);
    check("final_instret", instret, exp_instret);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
- Multicycle control FSM for the RV32I core.
- Sequences one shared datapath: single ALU, unified instruction/data memory port, register file, and the immediate generator output used as an ALU operand.
- Decodes the opcode captured in the instruction register and drives mux selects and write strobes each cycle.
- Handles the memory ready handshake, counts retired instructions, and traps on illegal opcodes or memory timeout.

Parameters:
- MEM_TIMEOUT, 15, maximum wait cycles for mem_ready in one memory state; 0 disables the timeout.
- CNT_W, 32, width of the instret counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- opcode  in  7  instruction register bits [6:0]
- mem_ready  in  1  memory access complete this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  memory write enable, valid with mem_req
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  capture fetched word into IR and old-PC register
- pc_write  out  1  unconditional PC update
- pc_write_cond  out  1  PC update qualified by the datapath branch-taken flag
- pc_src  out  2  0 = ALU result, 1 = ALUOut register, 2 = ALU result with bit0 cleared
- alu_src_a  out  2  0 = PC, 1 = rs1, 2 = old PC
- alu_src_b  out  2  0 = rs2, 1 = constant 4, 2 = immediate
- alu_op  out  2  0 = add, 1 = branch compare, 2 = funct-decoded
- reg_write  out  1  register file write
- mem_to_reg  out  2  0 = ALUOut, 1 = MDR, 2 = PC (link)
- halted  out  1  FSM in TRAP
- trap_cause  out  2  0 = none, 1 = illegal opcode, 2 = bus timeout
- instret  out  CNT_W  retired instruction count

Behaviour:
- Reset (asynchronous):
  - state = FETCH; wait counter, instret and trap_cause = 0.
  - While rst is high, all outputs are forced to 0, including the combinational FETCH outputs.
- Outputs are decoded from state (Moore), except FETCH strobes, which are qualified by mem_ready. Any select not listed for a state is 0.
- FETCH:
  - mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 1, alu_op = 0.
  - On mem_ready: ir_write = 1, pc_write = 1, pc_src = 0 (PC + 4), next state DECODE.
  - Otherwise hold in FETCH.
- DECODE: alu_src_a = 2, alu_src_b = 2, alu_op = 0 (ALUOut <= oldPC + imm). Next state by opcode:
  - 0000011 or 0100011 -> MEM_ADDR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - any other opcode -> TRAP, trap_cause = 1
- MEM_ADDR: alu_src_a = 1, alu_src_b = 2, alu_op = 0. Next MEM_RD if opcode = 0000011, else MEM_WR.
- MEM_RD: mem_req = 1, iord = 1; hold until mem_ready, then LD_WB.
- LD_WB: reg_write = 1, mem_to_reg = 1; next FETCH.
- MEM_WR: mem_req = 1, mem_we = 1, iord = 1; hold until mem_ready, then FETCH.
- EXEC_R: alu_src_a = 1, alu_src_b = 0, alu_op = 2; next ALU_WB.
- EXEC_I: alu_src_a = 1, alu_src_b = 2, alu_op = 2; next ALU_WB.
- ALU_WB: reg_write = 1, mem_to_reg = 0; next FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 0, alu_op = 1, pc_write_cond = 1, pc_src = 1; next FETCH.
- JAL: pc_write = 1, pc_src = 1, reg_write = 1, mem_to_reg = 2; next FETCH. The link value is the pre-edge PC (oldPC + 4).
- JALR: alu_src_a = 1, alu_src_b = 2, alu_op = 0, pc_write = 1, pc_src = 2, reg_write = 1, mem_to_reg = 2; next FETCH.
- TRAP: all strobes and mem_req = 0, halted = 1. Absorbing state, left only by rst.
- Wait counter:
  - Increments each cycle the FSM is in FETCH, MEM_RD or MEM_WR with mem_ready = 0.
  - Clears on any state change.
  - When it equals MEM_TIMEOUT with mem_ready still 0 and MEM_TIMEOUT != 0: next state TRAP, trap_cause = 2.
  - A mem_ready arriving in the same cycle wins over the timeout.
- instret:
  - +1 on each transition into FETCH from LD_WB, MEM_WR (completed), ALU_WB, BRANCH, JAL or JALR.
  - Wraps modulo 2^CNT_W; does not count in TRAP.
- Latency with zero-wait memory, counted from FETCH entry to the next FETCH:
  - R/I-type: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch/JAL/JALR: 3 cycles
- Reset mid-access: mem_req drops asynchronously. A mem_ready arriving after reset release is meaningful only to the new FETCH.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - state encoding: 4-bit FETCH = 0 … TRAP = 12
  - RV32I opcode constants
  - alu_src_a, alu_src_b, alu_op, pc_src, mem_to_reg encodings
  - trap_cause codes
- One sub-module, mem_wait_timer: wait counter plus timeout compare. Inputs: active, mem_ready, state-change. Output: timeout.

Test Plan:
- rst, then opcode = 0010011, mem_ready = 1 constantly -> states FETCH, DECODE, EXEC_I, ALU_WB; reg_write = 1 in cycle 4 with mem_to_reg = 0; instret = 1 on re-entering FETCH.
- opcode = 0000011, mem_ready low for 3 cycles in MEM_RD -> mem_req/iord = 1 held 4 cycles; LD_WB asserts reg_write with mem_to_reg = 1; instret increments once.
- opcode = 1100111 -> JALR cycle shows pc_write = 1, pc_src = 2, reg_write = 1, mem_to_reg = 2, alu_src_b = 2.
- opcode = 1111111 in DECODE -> TRAP next cycle, halted = 1, trap_cause = 1; outputs stay 0 for 20 cycles; instret unchanged.
- MEM_TIMEOUT = 15, mem_ready held 0 in FETCH -> TRAP with trap_cause = 2 after the 16th FETCH cycle. Repeat with mem_ready = 1 in the timeout cycle -> DECODE, no trap.
- Assert rst asynchronously mid-MEM_WR -> mem_req and mem_we fall without waiting for clk; after release, FETCH with instret = 0 and trap_cause = 0.
